// File: rtl/audio_pkg.sv
// Shared mixer types and arithmetic helpers: FSM state, accumulator sizing, saturating narrow.
// Combinational only; no latency and no flow control.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } mix_state_e;

  localparam int SAT_W = 64;

  // Wide enough that NUM_CH full-scale products at maximum gain can never wrap.
  function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
    return in_w + gain_w + 1 + $clog2(num_ch);
  endfunction

  // Clamp a sign-extended value into the w-bit signed range.
  function automatic logic [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_clips(input logic signed [SAT_W-1:0] v, input int w);
    return (v > ((64'sd1 <<< (w - 1)) - 64'sd1)) || (v < -(64'sd1 <<< (w - 1)));
  endfunction

endpackage

// File: rtl/mix_mac.sv
// One-side signed-sample x unsigned-gain multiply-accumulate; clear wins over enable.
// Accumulator updates on the edge after en; no backpressure.
module mix_mac
  import audio_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int GAIN_W = 6,
  parameter int ACC_W  = acc_width(16, 6, 4)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  sample,
  input  logic [GAIN_W-1:0]       gain,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PROD_W = IN_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/audio_mixer.sv
// N-source stereo mixer: snapshot on next_sample, one MAC per channel per clock, saturate, register.
// out_valid NUM_CH+2 cycles after accept; strobes arriving while busy are dropped and flagged as overrun.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 24,
  parameter int GAIN_W     = 6,
  parameter int GAIN_SHIFT = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_sample,
  input  logic [NUM_CH*IN_W-1:0]   ch_left,
  input  logic [NUM_CH*IN_W-1:0]   ch_right,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]        ch_en_left,
  input  logic [NUM_CH-1:0]        ch_en_right,
  input  logic                     flags_clear,
  output logic [OUT_W-1:0]         left_out,
  output logic [OUT_W-1:0]         right_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     clip_l,
  output logic                     clip_r,
  output logic                     overrun
);

  localparam int ACC_W = acc_width(IN_W, GAIN_W, NUM_CH);
  localparam int IDX_W = $clog2(NUM_CH);

  mix_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_CH*IN_W-1:0]    snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [NUM_CH*GAIN_W-1:0]  snap_gain_q, snap_gain_d;
  logic [NUM_CH-1:0]         snap_en_l_q, snap_en_l_d, snap_en_r_q, snap_en_r_d;
  logic [OUT_W-1:0]          left_out_q, left_out_d, right_out_q, right_out_d;
  logic                      out_valid_q, out_valid_d, busy_q, busy_d;
  logic                      clip_l_q, clip_l_d, clip_r_q, clip_r_d, overrun_q, overrun_d;

  logic                      mac_clr;
  logic                      mac_en_l, mac_en_r;
  logic signed [IN_W-1:0]    smp_l, smp_r;
  logic [GAIN_W-1:0]         gain_cur;
  logic signed [ACC_W-1:0]   acc_l, acc_r, shr_l, shr_r;

  assign mac_clr  = (state_q == ST_IDLE) && next_sample;
  assign mac_en_l = (state_q == ST_ACC) && snap_en_l_q[idx_q];
  assign mac_en_r = (state_q == ST_ACC) && snap_en_r_q[idx_q];
  assign smp_l    = snap_l_q[idx_q*IN_W +: IN_W];
  assign smp_r    = snap_r_q[idx_q*IN_W +: IN_W];
  assign gain_cur = snap_gain_q[idx_q*GAIN_W +: GAIN_W];

  mix_mac #(.IN_W(IN_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_l (
    .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en_l),
    .sample(smp_l), .gain(gain_cur), .acc(acc_l)
  );

  mix_mac #(.IN_W(IN_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_r (
    .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en_r),
    .sample(smp_r), .gain(gain_cur), .acc(acc_r)
  );

  // Arithmetic shift floors toward -inf, matching a truncating DAC-side divide.
  assign shr_l = acc_l >>> GAIN_SHIFT;
  assign shr_r = acc_r >>> GAIN_SHIFT;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_l_d    = snap_l_q;
    snap_r_d    = snap_r_q;
    snap_gain_d = snap_gain_q;
    snap_en_l_d = snap_en_l_q;
    snap_en_r_d = snap_en_r_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    clip_l_d    = clip_l_q & ~flags_clear;
    clip_r_d    = clip_r_q & ~flags_clear;
    overrun_d   = overrun_q & ~flags_clear;

    case (state_q)
      ST_IDLE: begin
        if (next_sample) begin
          snap_l_d    = ch_left;
          snap_r_d    = ch_right;
          snap_gain_d = ch_gain;
          snap_en_l_d = ch_en_left;
          snap_en_r_d = ch_en_right;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_ACC;
        end
      end
      ST_ACC: begin
        if (next_sample) overrun_d = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (next_sample) overrun_d = 1'b1;
        left_out_d  = OUT_W'(sat_narrow(SAT_W'(shr_l), IN_W)) << (OUT_W - IN_W);
        right_out_d = OUT_W'(sat_narrow(SAT_W'(shr_r), IN_W)) << (OUT_W - IN_W);
        if (sat_clips(SAT_W'(shr_l), IN_W)) clip_l_d = 1'b1;
        if (sat_clips(SAT_W'(shr_r), IN_W)) clip_r_d = 1'b1;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      snap_l_q    <= '0;
      snap_r_q    <= '0;
      snap_gain_q <= '0;
      snap_en_l_q <= '0;
      snap_en_r_q <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_l_q    <= snap_l_d;
      snap_r_q    <= snap_r_d;
      snap_gain_q <= snap_gain_d;
      snap_en_l_q <= snap_en_l_d;
      snap_en_r_q <= snap_en_r_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
      overrun_q   <= overrun_d;
    end
  end

  assign left_out  = left_out_q;
  assign right_out = right_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: transaction-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_audio_mixer;
  localparam int NUM_CH = 4, IN_W = 16, OUT_W = 24, GAIN_W = 6, GAIN_SHIFT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, next_sample, flags_clear;
  logic [NUM_CH*IN_W-1:0]   ch_left, ch_right;
  logic [NUM_CH*GAIN_W-1:0] ch_gain;
  logic [NUM_CH-1:0]        ch_en_left, ch_en_right;
  logic [OUT_W-1:0]         left_out, right_out;
  logic                     out_valid, busy, clip_l, clip_r, overrun;

  audio_mixer #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W),
                .GAIN_SHIFT(GAIN_SHIFT)) dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .ch_left(ch_left), .ch_right(ch_right),
    .ch_gain(ch_gain), .ch_en_left(ch_en_left), .ch_en_right(ch_en_right),
    .flags_clear(flags_clear), .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .busy(busy), .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void mix_side(input logic [NUM_CH*IN_W-1:0] smp,
                                   input logic [NUM_CH*GAIN_W-1:0] gains,
                                   input logic [NUM_CH-1:0] en,
                                   output logic [OUT_W-1:0] res, output bit clip);
    longint sum, q, hi, lo;
    logic signed [IN_W-1:0] s;
    logic [GAIN_W-1:0] g;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      s = smp[i*IN_W +: IN_W];
      g = gains[i*GAIN_W +: GAIN_W];
      if (en[i]) sum = sum + longint'(s) * longint'(g);
    end
    q  = floor_div(sum, longint'(1) << GAIN_SHIFT);
    hi = (longint'(1) << (IN_W - 1)) - 1;
    lo = -(longint'(1) << (IN_W - 1));
    clip = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    res = OUT_W'(q * (longint'(1) << (OUT_W - IN_W)));
  endfunction

  int cyc = 0;
  int m_acc_t = 0;
  bit m_busy = 0, m_valid = 0, m_clip_l = 0, m_clip_r = 0, m_ovr = 0;
  bit p_cl, p_cr, set_l, set_r, set_o;
  logic [OUT_W-1:0] m_left = '0, m_right = '0, p_l, p_r;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0; m_valid = 0; m_clip_l = 0; m_clip_r = 0; m_ovr = 0;
      m_left = '0; m_right = '0;
    end else begin
      set_l = 0; set_r = 0; set_o = 0; m_valid = 0;
      if (m_busy) begin
        if (next_sample) set_o = 1;
        if (cyc == m_acc_t + NUM_CH + 1) begin
          m_left = p_l; m_right = p_r; set_l = p_cl; set_r = p_cr;
          m_valid = 1; m_busy = 0;
        end
      end else if (next_sample) begin
        mix_side(ch_left, ch_gain, ch_en_left, p_l, p_cl);
        mix_side(ch_right, ch_gain, ch_en_right, p_r, p_cr);
        m_acc_t = cyc;
        m_busy = 1;
      end
      m_clip_l = set_l | (m_clip_l & !flags_clear);
      m_clip_r = set_r | (m_clip_r & !flags_clear);
      m_ovr    = set_o | (m_ovr & !flags_clear);
    end
    cyc++;
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model_out_valid", out_valid, m_valid);
      chk("model_busy", busy, m_busy);
      chk("model_left", left_out, m_left);
      chk("model_right", right_out, m_right);
      chk("model_clip_l", clip_l, m_clip_l);
      chk("model_clip_r", clip_r, m_clip_r);
      chk("model_overrun", overrun, m_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [IN_W-1:0] l, input logic [IN_W-1:0] r,
                        input logic [GAIN_W-1:0] g);
    ch_left[i*IN_W +: IN_W]     = l;
    ch_right[i*IN_W +: IN_W]    = r;
    ch_gain[i*GAIN_W +: GAIN_W] = g;
  endtask

  task automatic wait_valid(output int n, output int bc);
    n = 0;
    bc = 0;
    while (!out_valid && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
  endtask

  task automatic run_mix(output int lat, output int bc);
    int n;
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    wait_valid(n, bc);
    lat = n + 1;
  endtask

  task automatic clear_flags();
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
  endtask

  task automatic unity_setup();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, '0, '0, 6'd32);
    set_ch(0, 16'd1000, 16'd0, 6'd32);
    ch_en_left  = 4'b0001;
    ch_en_right = 4'b0000;
  endtask

  int lat, bc, n, nv, v1, v2;

  initial begin
    rst = 1'b0; next_sample = 1'b0; flags_clear = 1'b0;
    ch_left = '0; ch_right = '0; ch_gain = '0; ch_en_left = '0; ch_en_right = '0;
    tick(); tick();
    chk("reset_left", left_out, 0);
    chk("reset_right", right_out, 0);
    chk("reset_ctrl", {out_valid, busy, clip_l, clip_r, overrun}, 0);
    rst = 1'b1;
    tick();

    // Unity single channel
    unity_setup();
    run_mix(lat, bc);
    chk("unity_latency", lat, 6);
    chk("unity_busy_cycles", bc, 5);
    chk("unity_busy_at_valid", busy, 0);
    chk("unity_left", left_out, 24'h03E800);
    chk("unity_right", right_out, 0);
    tick();

    // Positive saturation on left, small sum on right
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'h7FFF, 16'd100, 6'd63);
    ch_en_left = 4'b1111; ch_en_right = 4'b1111;
    run_mix(lat, bc);
    chk("possat_left", left_out, 24'h7FFF00);
    chk("possat_right", right_out, 24'h031300);
    tick();
    chk("possat_clip_l", clip_l, 1);
    chk("possat_clip_r", clip_r, 0);
    clear_flags();
    chk("clear_clip_l", clip_l, 0);

    // Negative saturation
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'h8000, 16'd0, 6'd32);
    ch_en_left = 4'b1111; ch_en_right = 4'b0000;
    run_mix(lat, bc);
    chk("negsat_left", left_out, 24'h800000);
    tick();
    chk("negsat_clip_l", clip_l, 1);
    clear_flags();

    // Floor rounding of small negatives
    for (int i = 0; i < NUM_CH; i++) set_ch(i, '0, '0, 6'd0);
    set_ch(0, 16'hFFFF, 16'hFFDF, 6'd1);
    ch_en_left = 4'b0001; ch_en_right = 4'b0001;
    run_mix(lat, bc);
    chk("floor_left", left_out, 24'hFFFF00);
    chk("floor_right", right_out, 24'hFFFE00);
    tick();
    chk("floor_no_clip", clip_l, 0);

    // Overrun and back-to-back
    unity_setup();
    next_sample = 1'b1; tick();
    next_sample = 1'b0; tick();
    tick();
    next_sample = 1'b1; tick();
    next_sample = 1'b0;
    chk("overrun_set", overrun, 1);
    nv = 0; v1 = -1; v2 = -1;
    for (int c = 4; c <= 13; c++) begin
      if (out_valid) begin
        nv++;
        if (nv == 1) v1 = c; else v2 = c;
      end
      next_sample = (c == 6);
      tick();
    end
    next_sample = 1'b0;
    chk("b2b_valid_count", nv, 2);
    chk("b2b_first_valid", v1, 6);
    chk("b2b_second_valid", v2, 12);
    clear_flags();
    chk("overrun_cleared", overrun, 0);

    // Snapshot isolation and right routing disabled
    unity_setup();
    for (int i = 0; i < NUM_CH; i++) ch_right[i*IN_W +: IN_W] = 16'd12345;
    next_sample = 1'b1; tick();
    next_sample = 1'b0; tick();
    set_ch(0, 16'd5000, 16'd12345, 6'd63);
    wait_valid(n, bc);
    chk("snap_latency", n + 2, 6);
    chk("snap_left", left_out, 24'h03E800);
    chk("snap_right", right_out, 0);
    tick();

    // Gain zero contributes nothing
    unity_setup();
    set_ch(1, 16'd20000, 16'd0, 6'd0);
    ch_en_left = 4'b0011;
    run_mix(lat, bc);
    chk("gain0_left", left_out, 24'h03E800);
    tick();

    // Reset mid-mix
    unity_setup();
    next_sample = 1'b1; tick();
    next_sample = 1'b0; tick();
    next_sample = 1'b1; tick();
    next_sample = 1'b0;
    chk("pre_reset_overrun", overrun, 1);
    rst = 1'b0; tick();
    chk("midreset_left", left_out, 0);
    chk("midreset_ctrl", {out_valid, busy, clip_l, clip_r, overrun}, 0);
    rst = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) nv++;
      tick();
    end
    chk("midreset_no_valid", nv, 0);
    run_mix(lat, bc);
    chk("post_reset_latency", lat, 6);
    chk("post_reset_left", left_out, 24'h03E800);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Parametrised N-source stereo mixer; the next generation of the fixed two-source (PSG + PCM) summing stage ahead of the I2S DAC interface.
- On each next_sample strobe it snapshots all channel samples, then runs one multiply-accumulate per channel per clock using a single shared multiplier per side.
- Applies per-channel 6-bit gain and left/right enables, saturates, and presents a registered stereo word with a one-cycle valid strobe.
- Sticky clip and overrun flags are available to the register interface.

Parameters:
NUM_CH, 4, number of input channels (2..16)
IN_W, 16, signed input sample width
OUT_W, 24, output width (OUT_W >= IN_W); result left-justified
GAIN_W, 6, unsigned per-channel gain width
GAIN_SHIFT, 5, arithmetic right shift after accumulation (gain 32 = unity)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low (0 = reset)
next_sample  in  1  one-cycle sample strobe
ch_left  in  NUM_CH*IN_W  packed signed left samples, ch0 in LSBs
ch_right  in  NUM_CH*IN_W  packed signed right samples
ch_gain  in  NUM_CH*GAIN_W  packed unsigned gains
ch_en_left  in  NUM_CH  per-channel routing to left
ch_en_right  in  NUM_CH  per-channel routing to right
flags_clear  in  1  clears clip_l, clip_r and overrun
left_out  out  OUT_W  signed mixed left
right_out  out  OUT_W  signed mixed right
out_valid  out  1  one-cycle strobe: new left_out/right_out
busy  out  1  mix in progress
clip_l  out  1  sticky: left saturated
clip_r  out  1  sticky: right saturated
overrun  out  1  sticky: next_sample dropped while busy

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; state IDLE; accumulators 0; channel index 0. Reset mid-mix aborts the mix with no out_valid.
- FSM IDLE -> ACC -> DONE -> IDLE.
- IDLE: next_sample=1 accepts a mix (cycle 0). On that edge the module snapshots ch_left, ch_right, ch_gain, ch_en_left and ch_en_right, clears both accumulators, sets idx=0 and enters ACC.
- ACC, cycles 1..NUM_CH: acc_l += en_l[idx] ? snap_l[idx]*gain[idx] : 0, with the same rule on the right. idx increments each cycle. After idx=NUM_CH-1 the FSM enters DONE.
- Accumulator width is IN_W+GAIN_W+1+clog2(NUM_CH); it never wraps. Products are signed x zero-extended gain.
- DONE, cycle NUM_CH+1:
  - r = acc >>> GAIN_SHIFT, an arithmetic shift that floors toward -inf.
  - Saturate r to the IN_W signed range.
  - Output = saturated value << (OUT_W-IN_W), with zero LSBs.
  - left_out and right_out are registered, out_valid is asserted, and the FSM returns to IDLE.
  - If saturation occurred, clip_l or clip_r is set on the same edge.
- Latency: out_valid=1 exactly in cycle NUM_CH+2 relative to the accept cycle. left_out and right_out hold until the next out_valid.
- busy=1 in ACC and DONE only, i.e. cycles 1..NUM_CH+1.
- next_sample while busy: ignored and overrun is set. next_sample in the out_valid cycle (state IDLE) is accepted normally.
- Input changes after the snapshot do not affect the mix in progress.
- flags_clear clears the sticky flags on the next edge. A set and a clear in the same cycle: set wins.
- A gain of 0 or a disabled enable contributes 0. All channels disabled gives output 0.

Decomposition:
- A package audio_pkg holds:
  - the state enum (IDLE/ACC/DONE);
  - the accumulator width function;
  - a saturating-narrow function, shared with later DAC-side blocks.
- One sub-module, mix_mac: a single-side signed x unsigned multiply-accumulate with clear and enable. It is instantiated twice, once for left and once for right.

Test Plan:
- Unity single channel: ch0 L=1000, gain 32, en_l=0001, all other channels 0, strobe. Required: out_valid at cycle 6, left_out=256000 (0x03E800), right_out=0, busy high in cycles 1..5.
- Positive saturation: all 4 channels L=32767, gain 63, all enabled. Required: left_out=0x7FFF00, clip_l=1, clip_r=0. After flags_clear: clip_l=0.
- Negative and floor rounding:
  - four channels at -32768, gain 32 -> left_out=0x800000, clip_l=1.
  - separately, ch0=-1, gain 1, rest 0 -> left_out=0xFFFF00.
- Overrun and back-to-back:
  - strobe at cycle 0 and again at cycle 3 -> second strobe dropped, overrun=1, exactly one out_valid (cycle 6).
  - strobe at cycle 6 -> accepted, out_valid at cycle 12.
- Snapshot and routing: change ch_left/ch_gain at cycle 2 -> output reflects the cycle-0 values. With ch_en_right=0000 -> right_out=0 regardless of ch_right.
- Reset mid-mix: rst=0 at cycle 3 -> all outputs 0 next cycle, no out_valid. A strobe after reset is released mixes normally.
